// File: rtl/albers_scene_ctrl.sv
// Scene sequencer for the nested-rectangle pattern: captures random layer targets on a beat,
// commits them at frame boundaries and animates half-extents toward them by STEP per frame.
module albers_scene_ctrl #(
  parameter int NUM_LAYERS = 7,
  parameter int STEP       = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        beat,
  input  logic        frame_start,
  input  logic [12:0] rnd_in,
  input  logic [2:0]  layer_sel,
  output logic [9:0]  layer_hw,
  output logic [9:0]  layer_hh,
  output logic [11:0] layer_rgb,
  output logic        busy,
  output logic        scene_done
);

  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [3:0] NL_W   = 4'(NUM_LAYERS);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PENDING, S_ANIMATE} state_t;

  state_t                        r_state;
  logic                          r_beat_pend;
  logic [2:0]                    r_idx;
  logic                          r_busy;
  logic                          r_done;
  logic [9:0]                    r_layer_hw, r_layer_hh;
  logic [11:0]                   r_layer_rgb;
  logic [NUM_LAYERS-1:0][9:0]    r_tgt_hw, r_tgt_hh, r_cur_hw, r_cur_hh;
  logic [NUM_LAYERS-1:0][11:0]   r_tgt_rgb, r_cur_rgb;
  logic [NUM_LAYERS-1:0][9:0]    w_nxt_hw, w_nxt_hh;
  logic                          w_conv;

  // One animation step: snap to target when within STEP, otherwise move STEP toward it.
  function automatic logic [9:0] f_step(input logic [9:0] cur, input logic [9:0] tgt);
    if (tgt >= cur) return ((tgt - cur) <= STEP_W) ? tgt : cur + STEP_W;
    else            return ((cur - tgt) <= STEP_W) ? tgt : cur - STEP_W;
  endfunction

  always_comb begin
    w_nxt_hw = r_cur_hw;
    w_nxt_hh = r_cur_hh;
    w_conv   = 1'b1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_nxt_hw[i] = f_step(r_cur_hw[i], r_tgt_hw[i]);
      w_nxt_hh[i] = f_step(r_cur_hh[i], r_tgt_hh[i]);
      if (w_nxt_hw[i] != r_tgt_hw[i] || w_nxt_hh[i] != r_tgt_hh[i]) w_conv = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_beat_pend <= 1'b0;
      r_idx       <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_layer_hw  <= 10'd0;
      r_layer_hh  <= 10'd0;
      r_layer_rgb <= 12'd0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_tgt_hw[i]  <= 10'(16 + 32 * i);
        r_tgt_hh[i]  <= 10'(16 + 32 * i);
        r_cur_hw[i]  <= 10'(16 + 32 * i);
        r_cur_hh[i]  <= 10'(16 + 32 * i);
        r_tgt_rgb[i] <= 12'd0;
        r_cur_rgb[i] <= 12'd0;
      end
    end else begin
      r_done <= 1'b0;

      if ({1'b0, layer_sel} < NL_W) begin
        r_layer_hw  <= r_cur_hw[layer_sel];
        r_layer_hh  <= r_cur_hh[layer_sel];
        r_layer_rgb <= r_cur_rgb[layer_sel];
      end else begin
        r_layer_hw  <= 10'd0;
        r_layer_hh  <= 10'd0;
        r_layer_rgb <= 12'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (beat || r_beat_pend) begin
            r_state     <= S_CAPTURE;
            r_idx       <= 3'd0;
            r_beat_pend <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_busy      <= 1'b0;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_idx == 3'(i)) begin
              r_tgt_hw[i]  <= {5'd0, rnd_in[4:0]} + 10'(32 * i + 16);
              r_tgt_hh[i]  <= {5'd0, rnd_in[9:5]} + 10'(32 * i + 16);
              r_tgt_rgb[i] <= rnd_in[12:1];
            end
          end
          if (r_idx == 3'(NUM_LAYERS - 1)) r_state <= S_PENDING;
          else                             r_idx   <= r_idx + 3'd1;
        end
        S_PENDING, S_ANIMATE: begin
          if (beat) r_beat_pend <= 1'b1;
          if (frame_start) begin
            r_cur_hw <= w_nxt_hw;
            r_cur_hh <= w_nxt_hh;
            if (r_state == S_PENDING) r_cur_rgb <= r_tgt_rgb;
            if (w_conv) begin
              // A beat arriving with the converging frame still queues a new capture.
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= r_beat_pend | beat;
            end else begin
              r_state <= S_ANIMATE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign layer_hw   = r_layer_hw;
  assign layer_hh   = r_layer_hh;
  assign layer_rgb  = r_layer_rgb;
  assign busy       = r_busy;
  assign scene_done = r_done;

endmodule

// File: tb/tb_albers_scene_ctrl.sv
// Directed-sequence bench for albers_scene_ctrl with random LFSR words checked against a
// per-layer arithmetic model of target capture, commit and per-frame stepping.
module tb_albers_scene_ctrl;
  localparam int NL = 7;
  localparam int ST = 4;

  logic        clk_in = 1'b0;
  logic        reset, beat, frame_start;
  logic [12:0] rnd_in;
  logic [2:0]  layer_sel;
  logic [9:0]  layer_hw, layer_hh;
  logic [11:0] layer_rgb;
  logic        busy, scene_done;

  albers_scene_ctrl #(.NUM_LAYERS(NL), .STEP(ST)) dut (
    .clk_in(clk_in), .reset(reset), .beat(beat), .frame_start(frame_start),
    .rnd_in(rnd_in), .layer_sel(layer_sel), .layer_hw(layer_hw), .layer_hh(layer_hh),
    .layer_rgb(layer_rgb), .busy(busy), .scene_done(scene_done)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0, sd_cnt = 0;
  int m_cur_hw[NL], m_cur_hh[NL], m_cur_rgb[NL];
  int m_tgt_hw[NL], m_tgt_hh[NL], m_tgt_rgb[NL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    if (scene_done === 1'b1) sd_cnt++;
    rnd_in = 13'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_cur_hw[i] = 16 + 32 * i; m_tgt_hw[i] = 16 + 32 * i;
      m_cur_hh[i] = 16 + 32 * i; m_tgt_hh[i] = 16 + 32 * i;
      m_cur_rgb[i] = 0;          m_tgt_rgb[i] = 0;
    end
  endtask

  function automatic int toward(input int c, input int t);
    int d = t - c;
    if (d >= -ST && d <= ST) return t;
    return (d > 0) ? c + ST : c - ST;
  endfunction

  task automatic read_all(input string tag);
    for (int s = 0; s < 8; s++) begin
      layer_sel = 3'(s);
      cyc();
      chk($sformatf("%s_hw%0d", tag, s),  32'(layer_hw),  (s < NL) ? m_cur_hw[s]  : 0);
      chk($sformatf("%s_hh%0d", tag, s),  32'(layer_hh),  (s < NL) ? m_cur_hh[s]  : 0);
      chk($sformatf("%s_rgb%0d", tag, s), 32'(layer_rgb), (s < NL) ? m_cur_rgb[s] : 0);
    end
  endtask

  task automatic pulse_beat(input bit with_frame);
    beat = 1'b1; frame_start = with_frame;
    cyc();
    beat = 1'b0; frame_start = 1'b0;
  endtask

  // Layer i samples the word present during the i-th capture cycle.
  task automatic capture_body(input string tag, input bit use_fixed, input logic [12:0] fixed_w,
                              input logic [12:0] mask, input int fs_at);
    for (int i = 0; i < NL; i++) begin
      rnd_in = use_fixed ? fixed_w : (13'($urandom) | mask);
      frame_start = (i == fs_at);
      chk($sformatf("%s_busy_cap%0d", tag, i), 32'(busy), 1);
      m_tgt_hw[i]  = int'(rnd_in[4:0]) + 32 * i + 16;
      m_tgt_hh[i]  = int'(rnd_in[9:5]) + 32 * i + 16;
      m_tgt_rgb[i] = int'(rnd_in[12:1]);
      cyc();
      frame_start = 1'b0;
    end
    chk({tag, "_busy_pend"}, 32'(busy), 1);
  endtask

  task automatic frame_once(input string tag, input bit first, output bit conv);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    conv = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (first) m_cur_rgb[i] = m_tgt_rgb[i];
      m_cur_hw[i] = toward(m_cur_hw[i], m_tgt_hw[i]);
      m_cur_hh[i] = toward(m_cur_hh[i], m_tgt_hh[i]);
      if (m_cur_hw[i] != m_tgt_hw[i] || m_cur_hh[i] != m_tgt_hh[i]) conv = 1'b0;
    end
    chk({tag, "_done"}, 32'(scene_done), 32'(conv));
  endtask

  task automatic run_frames(input string tag, input bit first);
    bit conv = 1'b0;
    bit f = first;
    for (int k = 0; k < 20 && !conv; k++) begin
      frame_once($sformatf("%s_f%0d", tag, k), f, conv);
      f = 1'b0;
    end
    chk({tag, "_converged"}, 32'(conv), 1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_hw"}, 32'(layer_hw), 0);
    chk({tag, "_done"}, 32'(scene_done), 0);
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit conv;
    int sd0, low;
    reset = 1'b1; beat = 1'b0; frame_start = 1'b0; rnd_in = 13'd0; layer_sel = 3'd0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(scene_done), 0);
    chk("rst_rgb_out", 32'(layer_rgb), 0);
    reset = 1'b0;
    model_reset();
    read_all("rst");

    // Fixed all-ones scene: every layer moves 31 pixels, so 8 frames to converge.
    sd0 = sd_cnt;
    pulse_beat(1'b0);
    capture_body("fix", 1'b1, 13'h1FFF, 13'h0, -1);
    for (int k = 1; k <= 8; k++) begin
      frame_once($sformatf("fix_f%0d", k), k == 1, conv);
      layer_sel = 3'd0;
      cyc();
      if (k == 1) begin
        chk("fix_hw0_f1", 32'(layer_hw), 20);
        chk("fix_rgb0_f1", 32'(layer_rgb), 32'h0FFF);
      end
      if (k == 8) chk("fix_hw0_f8", 32'(layer_hw), 47);
    end
    chk("fix_done_cnt", sd_cnt - sd0, 1);
    chk("fix_busy_idle", 32'(busy), 0);
    read_all("fix");

    // No frame_start for a long time: scene stays pending, active bank untouched.
    pulse_beat(1'b0);
    capture_body("hold", 1'b0, 13'h0, 13'h0, -1);
    low = 0;
    repeat (1000) begin
      cyc();
      if (busy !== 1'b1) low++;
    end
    chk("hold_busy_low_cycles", low, 0);
    read_all("hold");
    run_frames("hold", 1'b1);
    cyc();
    chk("hold_busy_end", 32'(busy), 0);
    read_all("hold_end");

    // Two extra beats during animation queue exactly one new capture.
    do_reset("q_rst");
    sd0 = sd_cnt;
    pulse_beat(1'b0);
    capture_body("q1", 1'b0, 13'h0, 13'h0210, -1);
    frame_once("q_f0", 1'b1, conv);
    pulse_beat(1'b0);
    cyc();
    pulse_beat(1'b0);
    conv = 1'b0;
    for (int k = 1; k < 20 && !conv; k++) frame_once($sformatf("q_f%0d", k), 1'b0, conv);
    chk("q_conv", 32'(conv), 1);
    chk("q_busy_queued", 32'(busy), 1);
    cyc();
    chk("q_done_single", 32'(scene_done), 0);
    capture_body("q2", 1'b0, 13'h0, 13'h0, -1);
    read_all("q2_pend");
    run_frames("q2", 1'b1);
    cyc(); cyc(); cyc();
    chk("q_busy_after", 32'(busy), 0);
    chk("q_done_cnt", sd_cnt - sd0, 2);
    read_all("q2");

    // Beat with frame_start in idle, plus frame_start mid-capture: no early commit.
    pulse_beat(1'b1);
    capture_body("sim", 1'b0, 13'h0, 13'h0, 3);
    read_all("sim_pend");
    run_frames("sim", 1'b1);
    read_all("sim");

    // Reset after the third frame of an animation.
    do_reset("ra_rst");
    pulse_beat(1'b0);
    capture_body("ra", 1'b0, 13'h0, 13'h0210, -1);
    for (int k = 0; k < 3; k++) frame_once($sformatf("ra_f%0d", k), k == 0, conv);
    sd0 = sd_cnt;
    reset = 1'b1;
    #2;
    chk("ra_busy", 32'(busy), 0);
    chk("ra_hw_out", 32'(layer_hw), 0);
    cyc();
    chk("ra_done", 32'(scene_done), 0);
    reset = 1'b0;
    model_reset();
    read_all("ra");
    chk("ra_no_done", sd_cnt - sd0, 0);
    chk("ra_busy_end", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
